// File: rtl/pmod_jstk_scheduler.sv
// rtl/pmod_jstk_scheduler.sv - round-robin SPI poller for two PmodJSTK joysticks on one bus
module pmod_jstk_scheduler #(
  parameter int SCK_HALF = 25,
  parameter int CS_SETUP = 750,
  parameter int BYTE_GAP = 500,
  parameter int IDLE_GAP = 50000
) (
  input  logic       clk50M,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] led0,
  input  logic [1:0] led1,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       cs0,
  output logic       cs1,
  output logic [9:0] y0,
  output logic [9:0] y1,
  output logic [1:0] btn0,
  output logic [1:0] btn1,
  output logic       upd,
  output logic       upd_dev
);

  // Phase counter spans one full SCK period (low half then high half).
  localparam int PH_MAX  = 2 * SCK_HALF - 1;
  localparam int PH_W    = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);
  // One counter serves both the CS setup and the inter-byte gap.
  localparam int CNT_MAX = ((CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP) - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  // The DONE cycle is already the first CS-high cycle, so IDLE waits two
  // fewer counts than IDLE_GAP to make CS-rise to CS-fall exactly IDLE_GAP.
  localparam int IDLE_TGT = (IDLE_GAP >= 2) ? IDLE_GAP - 2 : 0;
  localparam int IDLE_W   = (IDLE_TGT < 2) ? 1 : $clog2(IDLE_TGT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [5:0]          bit_q, bit_d;
  logic [7:0]          tx_q, tx_d;
  // Only r2..r4 matter; earlier bytes shift out of the top.
  logic [23:0]         rx_q, rx_d;
  logic                sel_q, sel_d;
  logic                upd_dev_q, upd_dev_d;
  logic [9:0]          y0_q, y0_d, y1_q, y1_d;
  logic [1:0]          btn0_q, btn0_d, btn1_q, btn1_d;
  logic                idle_done;
  logic                cs_active;

  assign idle_done = (idle_q == IDLE_W'(IDLE_TGT));

  // Next-state logic: transaction sequencing, bit shifting and result capture.
  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sel_d     = sel_q;
    upd_dev_d = upd_dev_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    btn0_d    = btn0_q;
    btn1_d    = btn1_q;
    case (state_q)
      S_IDLE: begin
        if (!idle_done) begin
          idle_d = idle_q + 1'b1;
        end else if (enable) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          tx_d    = {6'b100000, (sel_q ? led1 : led0)};
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // Sample on the clock edge that raises SCK.
        if (ph_q == PH_W'(SCK_HALF - 1)) begin
          rx_d = {rx_q[22:0], miso};
        end
        if (ph_q == PH_W'(PH_MAX)) begin
          ph_d = '0;
          if (bit_q == 6'd39) begin
            // Results are loaded on entry to DONE so they are valid while upd is high.
            state_d   = S_DONE;
            upd_dev_d = sel_q;
            if (sel_q) begin
              y1_d   = {rx_q[9:8], rx_q[23:16]};
              btn1_d = rx_q[2:1];
            end else begin
              y0_d   = {rx_q[9:8], rx_q[23:16]};
              btn0_d = rx_q[2:1];
            end
          end else begin
            bit_d = bit_q + 1'b1;
            if (bit_q[2:0] == 3'd7) begin
              state_d = S_GAP;
              cnt_d   = '0;
            end
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(BYTE_GAP - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          ph_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idle_d  = '0;
        sel_d   = ~sel_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any transaction in flight.
  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idle_q    <= IDLE_W'(IDLE_TGT);
      cnt_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sel_q     <= 1'b0;
      upd_dev_q <= 1'b0;
      y0_q      <= 10'd512;
      y1_q      <= 10'd512;
      btn0_q    <= 2'b00;
      btn1_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sel_q     <= sel_d;
      upd_dev_q <= upd_dev_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      btn0_q    <= btn0_d;
      btn1_q    <= btn1_d;
    end
  end

  assign cs_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_GAP);
  assign cs0       = ~(cs_active & ~sel_q);
  assign cs1       = ~(cs_active & sel_q);
  assign sck       = (state_q == S_SHIFT) && (ph_q >= PH_W'(SCK_HALF));
  // Only byte 0 carries data; bytes 1..4 are zero.
  assign mosi      = (state_q == S_SHIFT) && (bit_q < 6'd8) && tx_q[3'd7 - bit_q[2:0]];
  assign upd       = (state_q == S_DONE);
  assign upd_dev   = upd_dev_q;
  assign y0        = y0_q;
  assign y1        = y1_q;
  assign btn0      = btn0_q;
  assign btn1      = btn1_q;

endmodule

// File: tb/tb_pmod_jstk_scheduler.sv
// tb/tb_pmod_jstk_scheduler.sv - randomized scoreboard bench for pmod_jstk_scheduler
`timescale 1ns/1ps
module tb_pmod_jstk_scheduler;

  localparam int SCK_HALF = 2;
  localparam int CS_SETUP = 4;
  localparam int BYTE_GAP = 3;
  localparam int IDLE_GAP = 10;
  localparam int WIN      = CS_SETUP + 40 * 2 * SCK_HALF + 4 * BYTE_GAP;

  logic       clk50M  = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic [1:0] led0    = 2'b00;
  logic [1:0] led1    = 2'b00;
  logic       miso    = 1'b0;
  logic       sck, mosi, cs0, cs1, upd, upd_dev;
  logic [9:0] y0, y1;
  logic [1:0] btn0, btn1;

  pmod_jstk_scheduler #(
    .SCK_HALF(SCK_HALF),
    .CS_SETUP(CS_SETUP),
    .BYTE_GAP(BYTE_GAP),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk50M (clk50M),
    .reset_n(reset_n),
    .enable (enable),
    .led0   (led0),
    .led1   (led1),
    .miso   (miso),
    .sck    (sck),
    .mosi   (mosi),
    .cs0    (cs0),
    .cs1    (cs1),
    .y0     (y0),
    .y1     (y1),
    .btn0   (btn0),
    .btn1   (btn1),
    .upd    (upd),
    .upd_dev(upd_dev)
  );

  always #5 clk50M = ~clk50M;

  int vectors     = 0;
  int miscompares = 0;
  int n_cmp       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rbyte(input logic [39:0] r, input int i);
    return r[39 - 8 * i -: 8];
  endfunction

  // Inputs as seen by the design at each rising edge.
  int         edge_n = 0;
  logic       en_s   = 1'b0;
  logic       rst_s  = 1'b0;
  logic [1:0] led0_s = 2'b00;
  logic [1:0] led1_s = 2'b00;

  always @(posedge clk50M) begin
    edge_n++;
    en_s   = enable;
    rst_s  = reset_n;
    led0_s = led0;
    led1_s = led1;
  end

  // Reference model state: one transaction = WIN cs-low cycles, then IDLE_GAP cs-high cycles.
  int          m_busy     = 0;
  int          m_dev      = 0;
  int          m_earliest = 0;
  logic [9:0]  m_y [2]    = '{10'd512, 10'd512};
  logic [1:0]  m_btn [2]  = '{2'b00, 2'b00};
  logic [39:0] m_resp     = '0;
  logic [1:0]  m_led      = 2'b00;
  logic [39:0] cap        = '0;
  int          rise       = 0;
  int          run        = 0;
  logic        prev_sck   = 1'b0;
  logic        prev_mosi  = 1'b0;
  logic [7:0]  last_byte0 = 8'h00;
  logic [39:0] resp_plan  = '0;
  bit          resp_plan_v = 1'b0;

  always @(negedge clk50M) begin
    bit          started, ended;
    logic        ex_upd, ex_dev;
    int          lowexp;
    logic [7:0]  r2, r3, r4;
    logic [63:0] rnd;
    started = 1'b0;
    ended   = 1'b0;
    ex_upd  = 1'b0;
    ex_dev  = 1'b0;
    vectors++;

    if (!rst_s) begin
      m_busy     = 0;
      m_dev      = 0;
      m_earliest = edge_n + 1;
      m_y[0]     = 10'd512;
      m_y[1]     = 10'd512;
      m_btn[0]   = 2'b00;
      m_btn[1]   = 2'b00;
      rise       = 0;
      cap        = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        ended    = 1'b1;
        ex_upd   = 1'b1;
        ex_dev   = (m_dev != 0);
        r2       = rbyte(m_resp, 2);
        r3       = rbyte(m_resp, 3);
        r4       = rbyte(m_resp, 4);
        m_y[m_dev]   = {r3[1:0], r2};
        m_btn[m_dev] = r4[2:1];
        m_dev      = 1 - m_dev;
        m_earliest = edge_n + IDLE_GAP;
      end
    end else if (edge_n >= m_earliest && en_s) begin
      started = 1'b1;
      m_busy  = WIN;
      m_led   = (m_dev != 0) ? led1_s : led0_s;
      rnd     = {$urandom, $urandom};
      m_resp  = resp_plan_v ? resp_plan : rnd[39:0];
      resp_plan_v = 1'b0;
    end

    if (rst_s) begin
      if (started) begin
        chk("sck_low_at_cs_fall", sck, 1'b0);
        rise     = 0;
        cap      = '0;
        run      = 1;
        prev_sck = sck;
      end else if (m_busy > 0 || ended) begin
        if (sck !== prev_sck) begin
          if (sck) begin
            lowexp = SCK_HALF + ((rise == 0) ? CS_SETUP : ((rise % 8 == 0) ? BYTE_GAP : 0));
            chk("sck_low_width", run, lowexp);
            cap = {cap[38:0], mosi};
            rise++;
          end else begin
            chk("sck_high_width", run, SCK_HALF);
          end
          run = 1;
        end else begin
          run++;
          if (sck && prev_sck) chk("mosi_stable_sck_high", mosi, prev_mosi);
        end
        prev_sck = sck;
      end else begin
        chk("sck_low_outside_cs", sck, 1'b0);
      end
      if (ended) begin
        chk("rising_edges_per_cs", rise, 40);
        chk("mosi_byte0", cap[39:32], {6'b100000, m_led});
        chk("mosi_bytes1_4", cap[31:0], 32'h0);
        last_byte0 = cap[39:32];
      end
    end
    prev_mosi = mosi;

    miso = (m_busy > 0 && rise < 40) ? m_resp[39 - rise] : 1'b0;

    chk("cs0", cs0, !(m_busy > 0 && m_dev == 0));
    chk("cs1", cs1, !(m_busy > 0 && m_dev == 1));
    chk("upd", upd, ex_upd);
    if (ex_upd) chk("upd_dev", upd_dev, ex_dev);
    chk("y0", y0, m_y[0]);
    chk("y1", y1, m_y[1]);
    chk("btn0", btn0, m_btn[0]);
    chk("btn1", btn1, m_btn[1]);
  end

  task automatic wait_upd(input string name, input int limit);
    int n;
    n = 0;
    while (upd !== 1'b1 && n < limit) begin
      @(negedge clk50M);
      n++;
    end
    chk(name, (n < limit), 1'b1);
  endtask

  task automatic wait_bit(input string name, input int bitno, input int limit);
    int n;
    n = 0;
    while (!((cs0 === 1'b0 || cs1 === 1'b0) && rise == bitno) && n < limit) begin
      @(negedge clk50M);
      n++;
    end
    chk(name, (n < limit), 1'b1);
  endtask

  initial begin
    int cnt_upd;
    int n;

    repeat (3) @(negedge clk50M);
    chk("reset_cs0", cs0, 1'b1);
    chk("reset_cs1", cs1, 1'b1);
    chk("reset_sck", sck, 1'b0);
    chk("reset_mosi", mosi, 1'b0);
    chk("reset_y0", y0, 10'd512);
    chk("reset_y1", y1, 10'd512);
    chk("reset_btn0", btn0, 2'b00);
    chk("reset_btn1", btn1, 2'b00);
    chk("reset_upd", upd, 1'b0);
    chk("reset_upd_dev", upd_dev, 1'b0);

    resp_plan   = 40'h00_00_34_02_04;
    resp_plan_v = 1'b1;
    led0        = 2'b11;
    led1        = 2'b01;
    @(negedge clk50M);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk50M);
    chk("first_txn_no_idle_gap_cs0", cs0, 1'b0);
    wait_upd("t1_upd_timeout", 400);
    chk("t1_upd_dev", upd_dev, 1'b0);
    chk("t1_y0", y0, 10'h234);
    chk("t1_btn0", btn0, 2'b10);
    chk("t1_y1_held", y1, 10'd512);
    @(negedge clk50M);
    chk("t1_mosi_byte0", last_byte0, 8'h83);
    wait_upd("t2_upd_timeout", 400);
    chk("t2_upd_dev", upd_dev, 1'b1);
    @(negedge clk50M);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk50M);
      if ($urandom_range(0, 7) == 0) led0 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) led1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) enable = ~enable;
    end

    enable = 1'b1;
    wait_bit("reach_bit20_timeout", 20, 2000);
    enable  = 1'b0;
    cnt_upd = 0;
    repeat (500) begin
      @(negedge clk50M);
      if (upd === 1'b1) cnt_upd++;
    end
    chk("enable_drop_upd_count", cnt_upd, 1);
    chk("enable_drop_cs0_high", cs0, 1'b1);
    chk("enable_drop_cs1_high", cs1, 1'b1);

    enable = 1'b1;
    wait_bit("reach_byte3_timeout", 28, 2000);
    reset_n = 1'b0;
    @(negedge clk50M);
    chk("midreset_cs0", cs0, 1'b1);
    chk("midreset_cs1", cs1, 1'b1);
    chk("midreset_y0", y0, 10'd512);
    chk("midreset_y1", y1, 10'd512);
    reset_n = 1'b1;
    n = 0;
    while (cs0 === 1'b1 && cs1 === 1'b1 && n < 20) begin
      @(negedge clk50M);
      n++;
    end
    chk("post_reset_target_cs0", cs0, 1'b0);
    chk("post_reset_target_cs1", cs1, 1'b1);

    repeat (600) @(negedge clk50M);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule
